// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module  : alu_arb_pkg
// Purpose : Shared FSM encoding, width defaults and ID width for alu_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FUNC_WIDTH_DEF = 5;
  localparam int ID_WIDTH       = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-way grant; ptr_i selects the winner only when both request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (valid0_i && valid1_i) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end else if (valid0_i) begin
      gnt_o = 2'b01;
    end else if (valid1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Purpose : Arbitrates two requesters onto one shared combinational ALU.
//           Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FUNC_WIDTH = FUNC_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_PC,
  input  logic [DATA_WIDTH-1:0] REQ0_RS1,
  input  logic [DATA_WIDTH-1:0] REQ0_RS2,
  input  logic [DATA_WIDTH-1:0] REQ0_IMM,
  input  logic [FUNC_WIDTH-1:0] REQ0_CTRL,
  input  logic                  REQ0_MUX1,
  input  logic                  REQ0_MUX2,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ1_PC,
  input  logic [DATA_WIDTH-1:0] REQ1_RS1,
  input  logic [DATA_WIDTH-1:0] REQ1_RS2,
  input  logic [DATA_WIDTH-1:0] REQ1_IMM,
  input  logic [FUNC_WIDTH-1:0] REQ1_CTRL,
  input  logic                  REQ1_MUX1,
  input  logic                  REQ1_MUX2,
  output logic [DATA_WIDTH-1:0] PC_OUT,
  output logic [DATA_WIDTH-1:0] RS1_OUT,
  output logic [DATA_WIDTH-1:0] RS2_OUT,
  output logic [DATA_WIDTH-1:0] IMM_OUT,
  output logic [FUNC_WIDTH-1:0] ALU_CTRL,
  output logic                  MUX1_CTRL,
  output logic                  MUX2_CTRL,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  output logic                  RSP_VALID,
  output logic [ID_WIDTH-1:0]   RSP_ID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  input  logic                  RSP_READY
);

  state_e                state_q;
  logic [1:0]            gnt;
  logic                  ptr;
  logic                  grant_en;
  logic [DATA_WIDTH-1:0] pc_d, rs1_d, rs2_d, imm_d;
  logic [FUNC_WIDTH-1:0] ctrl_d;
  logic                  mux1_d, mux2_d;
  logic [DATA_WIDTH-1:0] pc_q, rs1_q, rs2_q, imm_q, rsp_data_q;
  logic [FUNC_WIDTH-1:0] ctrl_q;
  logic                  mux1_q, mux2_q, rsp_valid_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign ptr = 1'b0;
`else
  logic ptr_q;

  // Pointer favours whichever requester lost the most recent grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && gnt != 2'b00) begin
      ptr_q <= gnt[0];
    end
  end

  assign ptr = ptr_q;
`endif

  rr_arbiter2 u_arb (
    .valid0_i (REQ0_VALID),
    .valid1_i (REQ1_VALID),
    .ptr_i    (ptr),
    .gnt_o    (gnt)
  );

  // READY is gated by RST_N so nothing is accepted while reset is held.
  assign grant_en   = (state_q == IDLE) && RST_N;
  assign REQ0_READY = grant_en && gnt[0];
  assign REQ1_READY = grant_en && gnt[1];

  assign pc_d   = gnt[1] ? REQ1_PC   : REQ0_PC;
  assign rs1_d  = gnt[1] ? REQ1_RS1  : REQ0_RS1;
  assign rs2_d  = gnt[1] ? REQ1_RS2  : REQ0_RS2;
  assign imm_d  = gnt[1] ? REQ1_IMM  : REQ0_IMM;
  assign ctrl_d = gnt[1] ? REQ1_CTRL : REQ0_CTRL;
  assign mux1_d = gnt[1] ? REQ1_MUX1 : REQ0_MUX1;
  assign mux2_d = gnt[1] ? REQ1_MUX2 : REQ0_MUX2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      mux1_q      <= 1'b0;
      mux2_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            mux1_q   <= mux1_d;
            mux2_q   <= mux2_d;
            rsp_id_q <= gnt[1];
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= ALU_RESULT;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PC_OUT    = pc_q;
  assign RS1_OUT   = rs1_q;
  assign RS2_OUT   = rs2_q;
  assign IMM_OUT   = imm_q;
  assign ALU_CTRL  = ctrl_q;
  assign MUX1_CTRL = mux1_q;
  assign MUX2_CTRL = mux2_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_DATA  = rsp_data_q;

endmodule

`default_nettype wire
